// File: rtl/cp0.sv
// Coprocessor 0: exception/interrupt arbitration, SR/Cause/EPC/PRId and mfc0/mtc0/eret access.
// Optional feature macro: CP0_BD_EN (capture branch-delay flag and back EPC up by 4).
module cp0 #(
    parameter logic [31:0] PRID = 32'h2021_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] AddrSr    = 5'd12;
    localparam logic [4:0] AddrCause = 5'd13;
    localparam logic [4:0] AddrEpc   = 5'd14;
    localparam logic [4:0] AddrPrid  = 5'd15;

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic        bd_d;
    logic [31:0] epc_d;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = ie_q & ~exl_q & |(HWInt & im_q);
    assign exc_req = ~exl_q & (ExcCodeIn != 5'd0);
    assign Req     = int_req | exc_req;

`ifdef CP0_BD_EN
    assign bd_d  = BDIn;
    assign epc_d = BDIn ? VPC - 32'd4 : VPC;
`else
    logic unused_bd_in;
    assign unused_bd_in = BDIn;
    assign bd_d         = 1'b0;
    assign epc_d        = VPC;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            ip_q <= HWInt;
            if (Req) begin
                // Exception entry discards any concurrent mtc0.
                exl_q      <= 1'b1;
                exc_code_q <= int_req ? 5'd0 : ExcCodeIn;
                bd_q       <= bd_d;
                epc_q      <= epc_d;
            end else begin
                if (en) begin
                    case (CP0Addr)
                        AddrSr: begin
                            im_q  <= CP0In[15:10];
                            exl_q <= CP0In[1];
                            ie_q  <= CP0In[0];
                        end
                        AddrEpc: epc_q <= CP0In;
                        default: ;
                    endcase
                end
                // Later assignment wins: eret beats an SR write setting EXL.
                if (EXLClr) exl_q <= 1'b0;
            end
        end
    end

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Addr)
            AddrSr:    CP0Out = sr_val;
            AddrCause: CP0Out = cause_val;
            AddrEpc:   CP0Out = epc_q;
            AddrPrid:  CP0Out = PRID;
            default:   CP0Out = 32'd0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; expectations follow CP0_BD_EN if defined.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_checks = 0;
    int n_errors = 0;

    cp0 dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Addr   (CP0Addr),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0Addr = addr;
        #1;
        check(tag, CP0Out, exp);
    endtask

`ifdef CP0_BD_EN
    localparam logic [31:0] BdEpc   = 32'h0000_300C;
    localparam logic [31:0] BdCause = 32'h8000_0014;
`else
    localparam logic [31:0] BdEpc   = 32'h0000_3010;
    localparam logic [31:0] BdCause = 32'h0000_0014;
`endif

    initial begin
        reset = 1'b1; en = 1'b0; CP0Addr = 5'd0; CP0In = '0; VPC = '0; BDIn = 1'b0;
        ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_reg("rst_sr", 5'd12, 32'h0);
        check_reg("rst_cause", 5'd13, 32'h0);
        check_reg("rst_epc", 5'd14, 32'h0);
        check_reg("rst_prid", 5'd15, 32'h2021_0007);
        check_reg("rst_other", 5'd3, 32'h0);
        check("rst_req", {31'd0, Req}, 32'd1 - 32'd1);
        check("rst_epcout", EPCOut, 32'h0);

        // Overflow exception
        ExcCodeIn = 5'd12; VPC = 32'h0000_3008;
        #1;
        check("ov_req", {31'd0, Req}, 32'd1);
        tick();
        ExcCodeIn = 5'd0;
        check_reg("ov_cause", 5'd13, 32'h0000_0030);
        check_reg("ov_epc", 5'd14, 32'h0000_3008);
        check_reg("ov_sr", 5'd12, 32'h0000_0002);
        check("ov_req_after", {31'd0, Req}, 32'd0);

        // eret plus SR write on the same edge
        en = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0401; EXLClr = 1'b1;
        tick();
        en = 1'b0; EXLClr = 1'b0;
        check_reg("sr_write", 5'd12, 32'h0000_0401);

        // Interrupt beats AdEL
        HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_3020;
        #1;
        check("int_req", {31'd0, Req}, 32'd1);
        tick();
        check_reg("int_cause", 5'd13, 32'h0000_0400);
        check_reg("int_epc", 5'd14, 32'h0000_3020);
        check_reg("int_sr", 5'd12, 32'h0000_0403);

        // Masked while EXL=1
        ExcCodeIn = 5'd10; VPC = 32'h0000_3030;
        #1;
        check("exl_mask_req", {31'd0, Req}, 32'd0);
        tick();
        check_reg("exl_mask_cause", 5'd13, 32'h0000_0400);
        check_reg("exl_mask_epc", 5'd14, 32'h0000_3020);
        ExcCodeIn = 5'd0;

        // EXLClr wins over SR write setting EXL; level interrupt re-fires
        en = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0403; EXLClr = 1'b1;
        tick();
        en = 1'b0; EXLClr = 1'b0;
        check_reg("exlclr_sr", 5'd12, 32'h0000_0401);
        check("refire_req", {31'd0, Req}, 32'd1);
        HWInt = 6'b000000;
        #1;
        check("refire_drop", {31'd0, Req}, 32'd0);

        // AdES in a delay slot
        ExcCodeIn = 5'd5; VPC = 32'h0000_3010; BDIn = 1'b1;
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check_reg("bd_epc", 5'd14, BdEpc);
        check_reg("bd_cause", 5'd13, BdCause);
        check("bd_epcout", EPCOut, BdEpc);

        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // mtc0 EPC during exception entry is discarded
        ExcCodeIn = 5'd12; VPC = 32'h0000_3040;
        en = 1'b1; CP0Addr = 5'd14; CP0In = 32'hDEAD_BEEF;
        tick();
        en = 1'b0; ExcCodeIn = 5'd0;
        check("req_wr_epc", EPCOut, 32'h0000_3040);
        check_reg("req_wr_cause", 5'd13, 32'h0000_0030);

        // Write masks and read-only registers
        en = 1'b1; CP0Addr = 5'd12; CP0In = 32'hFFFF_FFFF;
        tick();
        CP0Addr = 5'd13;
        tick();
        CP0Addr = 5'd15;
        tick();
        CP0Addr = 5'd14; CP0In = 32'h1234_5678;
        tick();
        en = 1'b0;
        check_reg("sr_mask", 5'd12, 32'h0000_FC03);
        check_reg("cause_ro", 5'd13, 32'h0000_0030);
        check_reg("prid_ro", 5'd15, 32'h2021_0007);
        check_reg("epc_wr", 5'd14, 32'h1234_5678);

        // Reset dominates a pending request
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCodeIn = 5'd8; VPC = 32'h0000_3050; HWInt = 6'b000001;
        #1;
        check("pre_rst_req", {31'd0, Req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'b000000;
        check_reg("rst2_sr", 5'd12, 32'h0);
        check_reg("rst2_cause", 5'd13, 32'h0);
        check_reg("rst2_epc", 5'd14, 32'h0);
        check("rst2_req", {31'd0, Req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor 0 for the pipelined MIPS core. It receives the exception codes raised by the execute stage and the other stages: overflow (Ov), load address error (AdEL), store address error (AdES), plus RI and Syscall, merged upstream into one code. It also receives the six hardware interrupt lines. It decides whether to take an exception, records SR/Cause/EPC, and answers mfc0/mtc0/eret from the pipeline. It sits beside the memory stage; its `Req` output flushes the pipeline and redirects the PC to the handler.

## Interface
Parameters:
- `PRID`, default 32'h2021_0007: read-only value of register 15 (PRId).

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: mtc0 write enable.
- `CP0Addr`  in  5: register index for mtc0 write and mfc0 read (12 = SR, 13 = Cause, 14 = EPC, 15 = PRId).
- `CP0In`  in  32: mtc0 write data.
- `CP0Out`  out  32: mfc0 read data.
- `VPC`  in  32: PC of the instruction in the memory stage (the victim PC).
- `BDIn`  in  1: victim is in a branch delay slot.
- `ExcCodeIn`  in  5: pending exception code from the pipeline.
  - 0 = none, 4 = AdEL, 5 = AdES, 8 = Syscall, 10 = RI, 12 = Ov.
- `HWInt`  in  6: hardware interrupt lines (level-sensitive).
- `EXLClr`  in  1: eret in the memory stage.
- `EPCOut`  out  32: current EPC, used by eret.
- `Req`  out  1: take an exception or interrupt this cycle.

## Operation
SR (12):
- Bits [15:10] IM, [1] EXL, [0] IE.
- All other bits read 0.
- Writable by mtc0 on the implemented bits only.

Cause (13):
- Bit [31] BD, bits [15:10] IP, bits [6:2] ExcCode.
- All other bits read 0.
- Read-only: mtc0 writes are ignored.

EPC (14):
- Full 32 bits, writable by mtc0.

PRId (15):
- Constant `PRID`.
- Writes ignored.

Any other address reads 0 and ignores writes.

Request logic (combinational):
- `IntReq = IE & ~EXL & |(HWInt & IM)`.
- `ExcReq = ~EXL & (ExcCodeIn != 0)`.
- `Req = IntReq | ExcReq`.
- An interrupt takes priority over a synchronous exception in the same cycle.

On a rising edge with `Req`=1:
- EXL <= 1.
- ExcCode <= 0 if IntReq, else ExcCodeIn.
- BD <= BDIn.
- EPC <= BDIn ? VPC-4 : VPC, computed modulo 2^32. VPC is not realigned, so an AdEL on instruction fetch keeps its unaligned PC.
- Any mtc0 write in the same cycle is discarded.

On a rising edge with `Req`=0:
- If `en`=1, the mtc0 write is applied first.
- Then, if `EXLClr`=1, EXL <= 0. EXLClr wins over an SR write that sets EXL.

Every rising edge:
- Cause.IP <= HWInt, regardless of Req, en or EXL.

Outputs:
- `CP0Out` is a combinational read of the current register values. There is no write-through forwarding; hazards are handled by pipeline stalls.
- `EPCOut` is the EPC register.

## Timing
- `Req` is combinational: it is valid in the same cycle as `ExcCodeIn`/`HWInt`.
- Register effects are visible on `CP0Out`/`EPCOut` one cycle after the edge.
- Reset: SR, Cause and EPC are all 0.
  - Therefore `Req`=0, `CP0Out`=0 (or PRID when `CP0Addr`=15), and `EPCOut`=0.
- Reset dominates Req, en and EXLClr on the same edge.
- While EXL=1, all exceptions and interrupts are masked. Nested requests are dropped, not queued.
- HWInt is level-sensitive; an interrupt left asserted re-fires the cycle after eret clears EXL.

## Configuration
- `CP0_BD_EN` defined:
  - BD is captured from `BDIn`.
  - EPC = VPC-4 for a delay-slot victim.
- `CP0_BD_EN` undefined:
  - `BDIn` is ignored.
  - Cause.BD always reads 0.
  - EPC = VPC unconditionally.

## Test plan
- Reset, then read 12/13/14/15 -> 0, 0, 0, `PRID`; `Req`=0.
- ExcCodeIn=12, VPC=32'h0000_3008, BDIn=0 -> `Req`=1 in the same cycle; next cycle Cause=32'h0000_0030, EPC=32'h0000_3008, SR.EXL=1.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001 together with ExcCodeIn=4 -> ExcCode=0 (interrupt wins), Cause.IP=1.
- `CP0_BD_EN` defined; ExcCodeIn=5, VPC=32'h0000_3010, BDIn=1 -> EPC=32'h0000_300C, Cause[31]=1. Same stimulus with the macro undefined -> EPC=32'h0000_3010, Cause[31]=0.
- EXL=1 and ExcCodeIn=10 -> `Req`=0, registers unchanged; EXLClr=1 with mtc0 SR=32'h0000_0403 on the same edge -> SR reads 32'h0000_0401.
- `en`=1 with `Req`=1 writing EPC=32'hDEAD_BEEF -> EPC holds VPC, not DEADBEEF; `reset` with `Req`=1 -> all registers 0.
